// File: rtl/ex_pkg.sv
// Shared opcodes, result selectors, bus widths and divider state encoding for the EX stage.
// The EX_DIV_EN macro, consumed by ex.sv, enables the iterative divider.
package ex_pkg;

   localparam int REG_BUS_W  = 32;
   localparam int REG_ADDR_W = 5;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   localparam logic [7:0] EXE_NOP_OP  = 8'h00;
   localparam logic [7:0] EXE_AND_OP  = 8'h24;
   localparam logic [7:0] EXE_OR_OP   = 8'h25;
   localparam logic [7:0] EXE_XOR_OP  = 8'h26;
   localparam logic [7:0] EXE_NOR_OP  = 8'h27;
   localparam logic [7:0] EXE_SLL_OP  = 8'h7C;
   localparam logic [7:0] EXE_SRL_OP  = 8'h02;
   localparam logic [7:0] EXE_SRA_OP  = 8'h03;
   localparam logic [7:0] EXE_ADD_OP  = 8'h20;
   localparam logic [7:0] EXE_ADDU_OP = 8'h21;
   localparam logic [7:0] EXE_SUB_OP  = 8'h22;
   localparam logic [7:0] EXE_SUBU_OP = 8'h23;
   localparam logic [7:0] EXE_SLT_OP  = 8'h2A;
   localparam logic [7:0] EXE_SLTU_OP = 8'h2B;
   localparam logic [7:0] EXE_MFHI_OP = 8'h10;
   localparam logic [7:0] EXE_MTHI_OP = 8'h11;
   localparam logic [7:0] EXE_MFLO_OP = 8'h12;
   localparam logic [7:0] EXE_MTLO_OP = 8'h13;
   localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
   localparam logic [7:0] EXE_DIVU_OP = 8'h1B;

   localparam logic [2:0] EXE_RES_NOP   = 3'd0;
   localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
   localparam logic [2:0] EXE_RES_SHIFT = 3'd2;
   localparam logic [2:0] EXE_RES_MOVE  = 3'd3;
   localparam logic [2:0] EXE_RES_ARITH = 3'd4;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Magnitude of a word, treating it as signed only when is_signed is set.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs restored on the way out; divide-by-zero short-circuits to DONE.
module ex_div
   import ex_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);

   div_state_e  state_q, state_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [33:0] trial_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         rem_q   <= 32'h0;
         quo_q   <= 32'h0;
         dvs_q   <= 32'h0;
         cnt_q   <= 5'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      trial_s = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};
      case (state_q)
         DIV_IDLE: begin
            if (start_i) begin
               busy_o = 1'b1;
               cnt_d  = 5'd0;
               if (divisor_i == 32'h0) begin
                  rem_d   = dividend_i;
                  quo_d   = 32'hFFFF_FFFF;
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = DIV_DONE;
               end else begin
                  rem_d   = 32'h0;
                  quo_d   = mag32(dividend_i, signed_i);
                  dvs_d   = mag32(divisor_i, signed_i);
                  qneg_d  = signed_i & (dividend_i[31] ^ divisor_i[31]);
                  rneg_d  = signed_i & dividend_i[31];
                  state_d = DIV_RUN;
               end
            end else begin
               state_d = DIV_IDLE;
            end
         end
         DIV_RUN: begin
            busy_o = 1'b1;
            if (!trial_s[33]) begin
               rem_d = trial_s[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = {rem_q[30:0], quo_q[31]};
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DIV_DONE;
            end else begin
               state_d = DIV_RUN;
            end
         end
         DIV_DONE: begin
            done_o  = 1'b1;
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   assign quotient_o  = qneg_q ? (~quo_q + 32'd1) : quo_q;
   assign remainder_o = rneg_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/ex.sv
// MIPS32 execute stage: combinational ALU/shift/move result, HI/LO registers and
// divide stall control. Define EX_DIV_EN to build the DIV/DIVU divider.
module ex
   import ex_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            aluop_i,
   input  logic [2:0]            alusel_i,
   input  logic [REG_BUS_W-1:0]  reg1_i,
   input  logic [REG_BUS_W-1:0]  reg2_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [REG_BUS_W-1:0]  wdata_o,
   output logic                  stallreq_o,
   output logic [REG_BUS_W-1:0]  hi_o,
   output logic [REG_BUS_W-1:0]  lo_o
);

   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] sum_s, diff_s, logic_res_s, shift_res_s, arith_res_s, move_res_s;
   logic        ovf_s, div_busy_s, div_done_s, is_div_s;
   logic [31:0] div_quo_s, div_rem_s;

   assign is_div_s = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

`ifdef EX_DIV_EN
   ex_div u_div (
      .clk         (clk),
      .rst         (rst),
      .start_i     (is_div_s),
      .signed_i    (aluop_i == EXE_DIV_OP),
      .dividend_i  (reg1_i),
      .divisor_i   (reg2_i),
      .busy_o      (div_busy_s),
      .done_o      (div_done_s),
      .quotient_o  (div_quo_s),
      .remainder_o (div_rem_s)
   );
`else
   assign div_busy_s = 1'b0;
   assign div_done_s = 1'b0;
   assign div_quo_s  = ZERO_WORD;
   assign div_rem_s  = ZERO_WORD;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= ZERO_WORD;
         lo_q <= ZERO_WORD;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Divide completion has priority; MTHI/MTLO only commit when the pipeline is not held.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (div_done_s) begin
         hi_d = div_rem_s;
         lo_d = div_quo_s;
      end else if (!div_busy_s && (aluop_i == EXE_MTHI_OP)) begin
         hi_d = reg1_i;
      end else if (!div_busy_s && (aluop_i == EXE_MTLO_OP)) begin
         lo_d = reg1_i;
      end else begin
         hi_d = hi_q;
      end
   end

   always_comb begin
      sum_s       = reg1_i + reg2_i;
      diff_s      = reg1_i - reg2_i;
      logic_res_s = ZERO_WORD;
      shift_res_s = ZERO_WORD;
      arith_res_s = ZERO_WORD;
      move_res_s  = ZERO_WORD;
      ovf_s       = 1'b0;
      case (aluop_i)
         EXE_AND_OP:  logic_res_s = reg1_i & reg2_i;
         EXE_OR_OP:   logic_res_s = reg1_i | reg2_i;
         EXE_XOR_OP:  logic_res_s = reg1_i ^ reg2_i;
         EXE_NOR_OP:  logic_res_s = ~(reg1_i | reg2_i);
         EXE_SLL_OP:  shift_res_s = reg2_i << reg1_i[4:0];
         EXE_SRL_OP:  shift_res_s = reg2_i >> reg1_i[4:0];
         EXE_SRA_OP:  shift_res_s = $signed(reg2_i) >>> reg1_i[4:0];
         EXE_ADD_OP: begin
            arith_res_s = sum_s;
            ovf_s       = (reg1_i[31] == reg2_i[31]) && (sum_s[31] != reg1_i[31]);
         end
         EXE_ADDU_OP: arith_res_s = sum_s;
         EXE_SUB_OP: begin
            arith_res_s = diff_s;
            ovf_s       = (reg1_i[31] != reg2_i[31]) && (diff_s[31] != reg1_i[31]);
         end
         EXE_SUBU_OP: arith_res_s = diff_s;
         EXE_SLT_OP:  arith_res_s = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
         EXE_SLTU_OP: arith_res_s = {31'd0, reg1_i < reg2_i};
         EXE_MFHI_OP: move_res_s = hi_q;
         EXE_MFLO_OP: move_res_s = lo_q;
         default:     logic_res_s = ZERO_WORD;
      endcase
   end

   // Reset forces every output low, including the combinational forwarding triple.
   always_comb begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = ZERO_WORD;
      stallreq_o = 1'b0;
      hi_o       = ZERO_WORD;
      lo_o       = ZERO_WORD;
      if (!rst) begin
         wd_o       = wd_i;
         stallreq_o = div_busy_s;
         hi_o       = hi_q;
         lo_o       = lo_q;
         wreg_o     = wreg_i && !ovf_s && !is_div_s &&
                      (aluop_i != EXE_MTHI_OP) && (aluop_i != EXE_MTLO_OP);
         case (alusel_i)
            EXE_RES_LOGIC: wdata_o = logic_res_s;
            EXE_RES_SHIFT: wdata_o = shift_res_s;
            EXE_RES_ARITH: wdata_o = arith_res_s;
            EXE_RES_MOVE:  wdata_o = move_res_s;
            default:       wdata_o = ZERO_WORD;
         endcase
      end else begin
         wdata_o = ZERO_WORD;
      end
   end

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the EX stage; divider checks follow EX_DIV_EN.
module tb_ex;
   import ex_pkg::*;

   logic        clk;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stallreq_o;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int fails  = 0;
   int n;

   ex dut (
      .clk        (clk),
      .rst        (rst),
      .aluop_i    (aluop_i),
      .alusel_i   (alusel_i),
      .reg1_i     (reg1_i),
      .reg2_i     (reg2_i),
      .wd_i       (wd_i),
      .wreg_i     (wreg_i),
      .wd_o       (wd_o),
      .wreg_o     (wreg_o),
      .wdata_o    (wdata_o),
      .stallreq_o (stallreq_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wr);
      aluop_i  = op;
      alusel_i = sel;
      reg1_i   = a;
      reg2_i   = b;
      wd_i     = wd;
      wreg_i   = wr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Counts stall cycles starting with the current one; ends at the negedge of the first non-stalled cycle.
   task automatic count_stall(output int cnt);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (stallreq_o !== 1'b1) break;
         cnt++;
         next_cycle();
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_1100, 32'h0000_0020, 5'd3, 1'b1);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_wdata", wdata_o, 32'h0);
      chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
      chk("rst_wd", {27'd0, wd_o}, 32'd0);
      chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
      chk("rst_hi", hi_o, 32'h0);
      chk("rst_lo", lo_o, 32'h0);

      next_cycle();
      rst = 1'b0;
      #1;
      chk("or_wdata", wdata_o, 32'h0000_1120);
      chk("or_wreg", {31'd0, wreg_o}, 32'd1);
      chk("or_wd", {27'd0, wd_o}, 32'd3);

      drive(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd4, 1'b1);
      @(negedge clk); chk("and", wdata_o, 32'h00F0_1200);
      next_cycle();
      drive(EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd4, 1'b1);
      @(negedge clk); chk("xor", wdata_o, 32'hF0F0_0F0F);
      next_cycle();
      drive(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_0000, 32'h0000_FFFF, 5'd4, 1'b1);
      @(negedge clk); chk("nor", wdata_o, 32'hFFFF_0000);
      next_cycle();
      drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0004, 32'h0000_000F, 5'd5, 1'b1);
      @(negedge clk); chk("sll", wdata_o, 32'h0000_00F0);
      next_cycle();
      drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'hFFFF_FFE8, 32'h8000_0000, 5'd5, 1'b1);
      @(negedge clk); chk("srl", wdata_o, 32'h0080_0000);
      next_cycle();
      drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 5'd5, 1'b1);
      @(negedge clk); chk("sra", wdata_o, 32'hF800_0000);
      next_cycle();
      drive(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 1'b1);
      @(negedge clk); chk("slt", wdata_o, 32'h0000_0001);
      next_cycle();
      drive(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 1'b1);
      @(negedge clk); chk("sltu", wdata_o, 32'h0000_0000);
      next_cycle();
      drive(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 5'd7, 1'b1);
      @(negedge clk); chk("add_ovf_wreg", {31'd0, wreg_o}, 32'd0);
      next_cycle();
      drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 5'd7, 1'b1);
      @(negedge clk);
      chk("addu_wreg", {31'd0, wreg_o}, 32'd1);
      chk("addu_wdata", wdata_o, 32'h8000_0000);
      next_cycle();
      drive(EXE_SUB_OP, EXE_RES_ARITH, 32'h8000_0000, 32'h0000_0001, 5'd7, 1'b1);
      @(negedge clk); chk("sub_ovf_wreg", {31'd0, wreg_o}, 32'd0);
      next_cycle();
      drive(EXE_SUBU_OP, EXE_RES_ARITH, 32'h0000_0005, 32'h0000_0007, 5'd7, 1'b1);
      @(negedge clk);
      chk("subu_wdata", wdata_o, 32'hFFFF_FFFE);
      chk("subu_wreg", {31'd0, wreg_o}, 32'd1);
      next_cycle();
      drive(EXE_ADD_OP, EXE_RES_ARITH, 32'h0000_0003, 32'h0000_0004, 5'd7, 1'b1);
      @(negedge clk);
      chk("add_wdata", wdata_o, 32'h0000_0007);
      chk("add_wreg", {31'd0, wreg_o}, 32'd1);

      next_cycle();
      drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h1234_5678, 32'h0, 5'd0, 1'b1);
      @(negedge clk); chk("mthi_wreg", {31'd0, wreg_o}, 32'd0);
      next_cycle();
      chk("mthi_hi", hi_o, 32'h1234_5678);
      drive(EXE_MTLO_OP, EXE_RES_NOP, 32'h9ABC_DEF0, 32'h0, 5'd0, 1'b1);
      next_cycle();
      chk("mtlo_lo", lo_o, 32'h9ABC_DEF0);
      drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd8, 1'b1);
      @(negedge clk); chk("mfhi", wdata_o, 32'h1234_5678);
      next_cycle();
      drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd8, 1'b1);
      @(negedge clk); chk("mflo", wdata_o, 32'h9ABC_DEF0);
      next_cycle();
      drive(EXE_OR_OP, EXE_RES_NOP, 32'h0000_00FF, 32'h0000_FF00, 5'd9, 1'b1);
      @(negedge clk); chk("sel_nop", wdata_o, 32'h0);
      next_cycle();
      drive(EXE_OR_OP, 3'd7, 32'h0000_00FF, 32'h0000_FF00, 5'd9, 1'b1);
      @(negedge clk); chk("sel_unknown", wdata_o, 32'h0);
      next_cycle();

`ifdef EX_DIV_EN
      drive(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 1'b1);
      #1;
      chk("div_wreg", {31'd0, wreg_o}, 32'd0);
      count_stall(n);
      chk("div_stall_cycles", n, 32'd33);
      next_cycle();
      drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd11, 1'b1);
      @(negedge clk);
      chk("div_lo", lo_o, 32'hFFFF_FFFD);
      chk("div_hi", hi_o, 32'hFFFF_FFFF);
      chk("div_mflo", wdata_o, 32'hFFFF_FFFD);
      chk("div_mflo_stall", {31'd0, stallreq_o}, 32'd0);
      next_cycle();

      drive(EXE_DIVU_OP, EXE_RES_NOP, 32'h0000_0005, 32'h0000_0000, 5'd10, 1'b1);
      count_stall(n);
      chk("divz_stall_cycles", n, 32'd1);
      next_cycle();
      chk("divz_lo", lo_o, 32'hFFFF_FFFF);
      chk("divz_hi", hi_o, 32'h0000_0005);
      drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd10, 1'b1);
      count_stall(n);
      chk("b2b_stall_cycles", n, 32'd33);
      next_cycle();
      drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd12, 1'b1);
      @(negedge clk);
      chk("b2b_mfhi", wdata_o, 32'd2);
      chk("b2b_lo", lo_o, 32'd14);
      next_cycle();

      drive(EXE_DIV_OP, EXE_RES_NOP, 32'h0000_0007, 32'hFFFF_FFFE, 5'd10, 1'b1);
      count_stall(n);
      chk("divneg_stall_cycles", n, 32'd33);
      next_cycle();
      chk("divneg_lo", lo_o, 32'hFFFF_FFFD);
      chk("divneg_hi", hi_o, 32'h0000_0001);
`else
      drive(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 1'b1);
      @(negedge clk);
      chk("nodiv_wreg", {31'd0, wreg_o}, 32'd0);
      chk("nodiv_stall", {31'd0, stallreq_o}, 32'd0);
      next_cycle();
      chk("nodiv_hi", hi_o, 32'h1234_5678);
      chk("nodiv_lo", lo_o, 32'h9ABC_DEF0);
`endif

      drive(EXE_MTHI_OP, EXE_RES_NOP, 32'hAAAA_5555, 32'h0, 5'd0, 1'b0);
      next_cycle();
      drive(EXE_MTLO_OP, EXE_RES_NOP, 32'h5555_AAAA, 32'h0, 5'd0, 1'b0);
      next_cycle();
      chk("reload_hi", hi_o, 32'hAAAA_5555);
      chk("reload_lo", lo_o, 32'h5555_AAAA);

      drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd10, 1'b1);
      repeat (10) next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_stall", {31'd0, stallreq_o}, 32'd0);
      chk("midrst_wdata", wdata_o, 32'h0);
      next_cycle();
      rst = 1'b0;
      drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      chk("postrst_stall", {31'd0, stallreq_o}, 32'd0);
      chk("postrst_hi", hi_o, 32'h0);
      chk("postrst_lo", lo_o, 32'h0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
